// File: rtl/max_pool_ctrl_if.sv
// Handshake, SRAM and pooling-datapath signals for the max-pool sequencer.
interface max_pool_ctrl_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
);
    logic                start;
    logic [DIM_W-1:0]    fm_w;
    logic [DIM_W-1:0]    fm_h;
    logic [ADDR_W-1:0]   in_base;
    logic [ADDR_W-1:0]   out_base;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                win_valid;
    logic [4*DATA_W-1:0] win_data;
    logic [DATA_W-1:0]   pool_out;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    modport slave (
        input  start, fm_w, fm_h, in_base, out_base, rd_data, pool_out,
        output busy, done, rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, fm_w, fm_h, in_base, out_base, rd_data, pool_out,
        input  busy, done, rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/max_pool_ctrl.sv
// 2x2/stride-2 max-pool sequencer: window address generation, operand gather,
// latency tracking of the pooling pipeline and result write-back.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing window reads back-to-back
//   DRAIN | reads done, waiting for in-flight results to be written
//   DONE  | one-cycle completion pulse
module max_pool_ctrl #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 16,
    parameter int DIM_W    = 10,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    max_pool_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [DIM_W-1:0]    fw_q, fh_q, oc, orow, noc, norow, ow, oh;
    logic [ADDR_W-1:0]   row_ptr, nrow_ptr, naddr, rd_addr_q, wr_addr_q, fw_a;
    logic [1:0]          ph, nph, rd_ph_q;
    logic                rd_en_q, rd_vld, win_valid_q, wr_en_w;
    logic                last_col, last_row, last_rd, degenerate;
    logic [4*DATA_W-1:0] win_q;
    logic [PIPE_LAT-1:0] vdly;
    logic [7:0]          inflight, inflight_nxt;

    assign ow         = fw_q >> 1;
    assign oh         = fh_q >> 1;
    assign fw_a       = ADDR_W'(fw_q);
    assign last_col   = (oc == ow - 1'b1);
    assign last_row   = (orow == oh - 1'b1);
    assign last_rd    = rd_en_q && (ph == 2'd3) && last_col && last_row;
    assign degenerate = (bus.fm_w[DIM_W-1:1] == '0) || (bus.fm_h[DIM_W-1:1] == '0);
    assign wr_en_w    = vdly[PIPE_LAT-1];
    assign inflight_nxt = inflight + 8'(win_valid_q) - 8'(wr_en_w);

    // Address of the read following the one currently on rd_addr.
    always_comb begin
        nph      = ph + 2'd1;
        noc      = oc;
        norow    = orow;
        nrow_ptr = row_ptr;
        if (ph == 2'd3) begin
            if (last_col) begin
                noc      = '0;
                norow    = orow + 1'b1;
                nrow_ptr = row_ptr + ADDR_W'({fw_q, 1'b0});
            end else begin
                noc = oc + 1'b1;
            end
        end
        naddr = nrow_ptr + ADDR_W'({noc, 1'b0}) + (nph[1] ? fw_a : '0) + ADDR_W'(nph[0]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = degenerate ? DONE : FETCH;
            FETCH: if (last_rd) state_nxt = DRAIN;
            // rd_vld covers the gap between the last read and its win_valid.
            DRAIN: if ((inflight_nxt == '0) && !rd_vld) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_q        <= '0;
            fh_q        <= '0;
            oc          <= '0;
            orow        <= '0;
            ph          <= '0;
            row_ptr     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_vld      <= 1'b0;
            rd_ph_q     <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            vdly        <= '0;
            wr_addr_q   <= '0;
            inflight    <= '0;
        end else begin
            rd_vld      <= rd_en_q;
            rd_ph_q     <= ph;
            win_valid_q <= rd_vld && (rd_ph_q == 2'd3);
            vdly        <= (vdly << 1) | PIPE_LAT'(win_valid_q);
            inflight    <= inflight_nxt;
            if (rd_vld)
                win_q[int'(rd_ph_q)*DATA_W +: DATA_W] <= bus.rd_data;
            if (wr_en_w)
                wr_addr_q <= wr_addr_q + 1'b1;
            if (state == FETCH) begin
                if (last_rd) begin
                    rd_en_q <= 1'b0;
                end else begin
                    ph        <= nph;
                    oc        <= noc;
                    orow      <= norow;
                    row_ptr   <= nrow_ptr;
                    rd_addr_q <= naddr;
                end
            end
            if ((state == IDLE) && bus.start) begin
                fw_q      <= bus.fm_w;
                fh_q      <= bus.fm_h;
                oc        <= '0;
                orow      <= '0;
                ph        <= '0;
                row_ptr   <= bus.in_base;
                rd_addr_q <= bus.in_base;
                rd_en_q   <= !degenerate;
                wr_addr_q <= bus.out_base;
            end
        end
    end

    assign bus.busy      = (state == FETCH) || (state == DRAIN);
    assign bus.done      = (state == DONE);
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_q;
    assign bus.wr_en     = wr_en_w;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = bus.pool_out;
endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: SRAM and pooling-datapath stand-ins, a per-cycle
// trace model derived from window arithmetic, and directed runs with literal pins.
module tb_max_pool_ctrl;
    localparam int DATA_W = 20, ADDR_W = 16, DIM_W = 10, PIPE_LAT = 4;

    logic clk, rst_n;
    max_pool_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();
    max_pool_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .PIPE_LAT(PIPE_LAT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit run_active = 0;
    int start_cyc, m_fw, m_fh, m_ib, m_ob;
    logic [DATA_W-1:0] m_key;
    int rd_log[$], wr_addr_log[$], wr_data_log[$], pool_val[$], pool_due[$];
    int first_rd_j, first_wv_j, first_wr_j, done_j_seen, n_busy;
    bit prev_en = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int exp_rd[16];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_val(logic [ADDR_W-1:0] a);
        return {m_key[19:16], a ^ m_key[15:0]};
    endfunction

    function automatic logic [ADDR_W-1:0] m_addr(int i, int k);
        int ow, v;
        ow = m_fw / 2;
        v = m_ib + (2 * (i / ow) + k / 2) * m_fw + 2 * (i % ow) + k % 2;
        return ADDR_W'(v);
    endfunction

    task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SRAM/datapath stand-ins and the per-cycle compare against the window model.
    int c_j, c_w, c_dj, c_jw, c_i, c_mx;
    bit e_rd, e_wv, e_wr, e_busy, e_done;
    logic [79:0] c_win;
    logic [DATA_W-1:0] c_v;
    always @(negedge clk) begin
        bus.rd_data = prev_en ? mem_val(prev_addr) : '0;
        if (pool_due.size() > 0 && pool_due[0] == cyc) begin
            bus.pool_out = DATA_W'(pool_val[0]);
            void'(pool_val.pop_front());
            void'(pool_due.pop_front());
        end else begin
            bus.pool_out = 20'h0F0F0;
        end
        #1;
        {e_rd, e_wv, e_wr, e_busy, e_done} = '0;
        c_j = 0; c_dj = 0; c_jw = -1;
        if (run_active) begin
            c_j  = cyc - start_cyc;
            c_w  = (m_fw / 2) * (m_fh / 2);
            c_dj = (c_w > 0) ? 7 + 4 * (c_w - 1) + PIPE_LAT : 1;
            c_jw = c_j - 6 - PIPE_LAT;
            e_rd   = (c_j >= 1) && (c_j <= 4 * c_w);
            e_wv   = (c_j >= 6) && ((c_j - 6) % 4 == 0) && ((c_j - 6) / 4 < c_w);
            e_wr   = (c_jw >= 0) && (c_jw % 4 == 0) && (c_jw / 4 < c_w);
            e_busy = (c_j >= 1) && (c_j < c_dj);
            e_done = (c_j == c_dj);
        end
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("rd_en", bus.rd_en, e_rd);
        chk("win_valid", bus.win_valid, e_wv);
        chk("wr_en", bus.wr_en, e_wr);
        if (e_rd)
            chk("rd_addr", bus.rd_addr, m_addr((c_j - 1) / 4, (c_j - 1) % 4));
        if (e_wv) begin
            c_i = (c_j - 6) / 4;
            for (int k = 0; k < 4; k++) c_win[k*20 +: 20] = mem_val(m_addr(c_i, k));
            chk("win_data", bus.win_data, c_win);
        end
        if (e_wr) begin
            c_i = c_jw / 4;
            c_mx = 0;
            for (int k = 0; k < 4; k++) begin
                c_v = mem_val(m_addr(c_i, k));
                if (int'(c_v) > c_mx) c_mx = int'(c_v);
            end
            chk("wr_addr", bus.wr_addr, ADDR_W'(m_ob + c_i));
            chk("wr_data", bus.wr_data, DATA_W'(c_mx));
        end
        if (run_active) begin
            if (bus.rd_en) rd_log.push_back(int'(bus.rd_addr));
            if (bus.wr_en) begin
                wr_addr_log.push_back(int'(bus.wr_addr));
                wr_data_log.push_back(int'(bus.wr_data));
            end
            if (bus.rd_en && first_rd_j < 0) first_rd_j = c_j;
            if (bus.win_valid && first_wv_j < 0) first_wv_j = c_j;
            if (bus.wr_en && first_wr_j < 0) first_wr_j = c_j;
            if (bus.done && done_j_seen < 0) done_j_seen = c_j;
            if (bus.busy) n_busy++;
        end
        if (bus.win_valid) begin
            c_mx = 0;
            for (int k = 0; k < 4; k++)
                if (int'(bus.win_data[k*20 +: 20]) > c_mx) c_mx = int'(bus.win_data[k*20 +: 20]);
            pool_val.push_back(c_mx);
            pool_due.push_back(cyc + PIPE_LAT);
        end
        prev_en = bus.rd_en;
        prev_addr = bus.rd_addr;
        if (run_active && c_j >= c_dj) run_active = 0;
    end

    task automatic start_run(int fw, int fh, int ib, int ob, logic [DATA_W-1:0] key, int len);
        @(negedge clk);
        bus.fm_w = DIM_W'(fw);
        bus.fm_h = DIM_W'(fh);
        bus.in_base = ADDR_W'(ib);
        bus.out_base = ADDR_W'(ob);
        bus.start = 1;
        m_fw = fw; m_fh = fh; m_ib = ib; m_ob = ob; m_key = key;
        start_cyc = cyc;
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        first_rd_j = -1; first_wv_j = -1; first_wr_j = -1; done_j_seen = -1; n_busy = 0;
        run_active = 1;
        repeat (len) @(negedge clk);
        bus.start = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (run_active && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", run_active, 1'b0);
        run_active = 0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_rd_en"}, bus.rd_en, 1'b0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 16'h0);
        chk({tag, "_win_valid"}, bus.win_valid, 1'b0);
        chk({tag, "_win_data"}, bus.win_data, 80'h0);
        chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 16'h0);
    endtask

    initial begin
        rst_n = 1;
        bus.start = 0; bus.fm_w = '0; bus.fm_h = '0; bus.in_base = '0; bus.out_base = '0;
        bus.rd_data = '0; bus.pool_out = '0;
        m_key = '0; m_fw = 0; m_fh = 0; m_ib = 0; m_ob = 0; start_cyc = 0;
        #2 rst_n = 0;
        #1 chk_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1;

        // 4x4, data = address: raster windows and timing pins
        start_run(4, 4, 0, 'h100, 20'h0, 1);
        wait_done();
        exp_rd = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        chk("m44_rd_count", rd_log.size(), 16);
        for (int k = 0; k < 16 && k < rd_log.size(); k++) chk("m44_rd_seq", rd_log[k], exp_rd[k]);
        chk("m44_wr_count", wr_data_log.size(), 4);
        if (wr_data_log.size() == 4) begin
            chk("m44_wr0", wr_data_log[0], 5);
            chk("m44_wr1", wr_data_log[1], 7);
            chk("m44_wr2", wr_data_log[2], 13);
            chk("m44_wr3", wr_data_log[3], 15);
            chk("m44_wa3", wr_addr_log[3], 'h103);
        end
        chk("m44_first_rd", first_rd_j, 1);
        chk("m44_first_wv", first_wv_j, 6);
        chk("m44_first_wr", first_wr_j, 10);
        chk("m44_done", done_j_seen, 23);

        // 5x3: trailing column and row never read
        start_run(5, 3, 'h40, 'h20, 20'h3A5C3, 1);
        wait_done();
        exp_rd[0:7] = '{'h40, 'h41, 'h45, 'h46, 'h42, 'h43, 'h47, 'h48};
        chk("m53_rd_count", rd_log.size(), 8);
        for (int k = 0; k < 8 && k < rd_log.size(); k++) chk("m53_rd_seq", rd_log[k], exp_rd[k]);
        chk("m53_wr_count", wr_data_log.size(), 2);
        chk("m53_done", done_j_seen, 15);

        // 1x8: no work; start held into the DONE cycle must be ignored
        start_run(1, 8, 'h10, 'h10, 20'h11111, 2);
        wait_done();
        chk("m18_rd_count", rd_log.size(), 0);
        chk("m18_wr_count", wr_data_log.size(), 0);
        chk("m18_done", done_j_seen, 1);
        chk("m18_busy_cycles", n_busy, 0);
        repeat (4) @(negedge clk);

        // start and config changes mid-run are ignored
        start_run(4, 4, 40, 200, 20'h5F00F, 1);
        repeat (2) @(negedge clk);
        bus.start = 1; bus.in_base = 16'd999; bus.out_base = 16'd7; bus.fm_w = 10'd6; bus.fm_h = 10'd2;
        @(negedge clk);
        bus.start = 0;
        wait_done();
        chk("ign_first_rd", rd_log.size() > 0 ? rd_log[0] : -1, 40);
        chk("ign_wr_count", wr_addr_log.size(), 4);
        if (wr_addr_log.size() == 4) chk("ign_wa3", wr_addr_log[3], 203);

        // asynchronous reset during the second window's reads, then clean restart
        start_run(4, 4, 100, 50, 20'h2A0A0, 1);
        repeat (5) @(negedge clk);
        rst_n = 0;
        run_active = 0;
        pool_val.delete(); pool_due.delete();
        #1 chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        start_run(4, 4, 0, 'h300, 20'h00001, 1);
        wait_done();
        chk("rst_wr_count", wr_data_log.size(), 4);
        if (wr_data_log.size() == 4) begin
            chk("rst_wr0", wr_data_log[0], 5);
            chk("rst_wr3", wr_data_log[3], 15);
            chk("rst_wa0", wr_addr_log[0], 'h300);
        end

        // address wrap at the top of the SRAM
        start_run(4, 2, 'hFFFE, 0, 20'h0, 1);
        wait_done();
        exp_rd[0:7] = '{'hFFFE, 'hFFFF, 'h0002, 'h0003, 'h0000, 'h0001, 'h0004, 'h0005};
        chk("wrap_rd_count", rd_log.size(), 8);
        for (int k = 0; k < 8 && k < rd_log.size(); k++) chk("wrap_rd_seq", rd_log[k], exp_rd[k]);
        if (wr_data_log.size() == 2) begin
            chk("wrap_wr0", wr_data_log[0], 'hFFFF);
            chk("wrap_wr1", wr_data_log[1], 5);
        end else begin
            chk("wrap_wr_count", wr_data_log.size(), 2);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
